regwb_ctrl: RTL and testbench

Write-back controller and arbiter for the single register-file write port. Up to NREQ writeback sources (ALU result, load data, link address, ...) present register writes through valid/ready handshakes; the block arbitrates round-robin, drives the register file's address, data and rising-edge `write` strobe with correct setup ordering, and discards writes to `$zero`. It also exports a pending-write mask for hazard detection in the issue stage.

---
 rtl/regwb_ctrl.sv | 131 +++++++++++++
 tb/tb_regwb_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/regwb_ctrl.sv
// Register-file write-port controller: round-robin arbitration over NREQ writeback
// sources, SETUP/STROBE sequencing of the write strobe, $zero discard and pending-write mask.
module regwb_ctrl #(
  parameter int NREQ = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [5*NREQ-1:0] req_addr,
  input  logic [32*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [4:0]        rgw1,
  output logic [31:0]       rgw1data,
  output logic              write,
  output logic [31:0]       pend_mask,
  output logic              zero_drop,
  output logic              busy
);

  localparam int IDXW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE
  } state_e;

  state_e          state_q, state_d;
  logic [IDXW-1:0] last_q, last_d;
  logic [4:0]      rgw1_q, rgw1_d;
  logic [31:0]     data_q, data_d;
  logic [31:0]     pend_q, pend_d;
  logic            zero_drop_q, zero_drop_d;
  logic            write_q, write_d;
  logic            busy_q, busy_d;

  logic            arb_en;
  logic            win_found;
  logic [IDXW-1:0] win_idx;
  logic [4:0]      sel_addr;
  logic [31:0]     sel_data;
  logic            accept;

  // Round-robin search starts one past the last accepted requester.
  always_comb begin
    logic [IDXW-1:0] cand;
    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDXW'((int'(last_q) + k) % NREQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign arb_en   = (state_q == S_IDLE) || (state_q == S_STROBE);
  assign accept   = arb_en && win_found;
  assign sel_addr = req_addr[win_idx*5 +: 5];
  assign sel_data = req_data[win_idx*32 +: 32];
  // Gated by reset so no handshake completes while the block is held in reset.
  assign req_ready = (accept && reset) ? (NREQ'(1) << win_idx) : '0;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    rgw1_d      = rgw1_q;
    data_d      = data_q;
    pend_d      = pend_q;
    zero_drop_d = 1'b0;

    // Clear first so a same-register acceptance below re-sets the bit.
    if (state_q == S_STROBE) pend_d[rgw1_q] = 1'b0;

    unique case (state_q)
      S_IDLE, S_STROBE: begin
        state_d = S_IDLE;
        if (accept) begin
          last_d = win_idx;
          if (sel_addr != 5'd0) begin
            state_d          = S_SETUP;
            rgw1_d           = sel_addr;
            data_d           = sel_data;
            pend_d[sel_addr] = 1'b1;
          end else begin
            zero_drop_d = 1'b1;
          end
        end
      end
      S_SETUP: state_d = S_STROBE;
      default: state_d = S_IDLE;
    endcase

    write_d = (state_d == S_STROBE);
    busy_d  = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      last_q      <= IDXW'(NREQ - 1);
      rgw1_q      <= '0;
      data_q      <= '0;
      pend_q      <= '0;
      zero_drop_q <= 1'b0;
      write_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      rgw1_q      <= rgw1_d;
      data_q      <= data_d;
      pend_q      <= pend_d;
      zero_drop_q <= zero_drop_d;
      write_q     <= write_d;
      busy_q      <= busy_d;
    end
  end

  assign rgw1      = rgw1_q;
  assign rgw1data  = data_q;
  assign write     = write_q;
  assign pend_mask = pend_q;
  assign zero_drop = zero_drop_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_regwb_ctrl.sv
// Self-checking bench for regwb_ctrl: directed scenarios plus random traffic, compared
// against a transaction-history model (accept at cycle c -> strobe at c+2, pending c+1..c+2).
module tb_regwb_ctrl;

  localparam int NREQ = 3;
  localparam int MAXC = 1024;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [5*NREQ-1:0] req_addr;
  logic [32*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [4:0]        rgw1;
  logic [31:0]       rgw1data;
  logic              write;
  logic [31:0]       pend_mask;
  logic              zero_drop;
  logic              busy;

  regwb_ctrl #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rgw1      (rgw1),
    .rgw1data  (rgw1data),
    .write     (write),
    .pend_mask (pend_mask),
    .zero_drop (zero_drop),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: history of accepted writes indexed by cycle number.
  int          t = 0;
  int          hist_start = 0;
  bit          acc_nz[MAXC];
  bit          acc_zero[MAXC];
  logic [4:0]  acc_addr[MAXC];
  int          m_last = NREQ - 1;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  function automatic bit nz_at(input int c);
    return (c >= hist_start) && (c >= 0) && acc_nz[c];
  endfunction

  function automatic bit zero_at(input int c);
    return (c >= hist_start) && (c >= 0) && acc_zero[c];
  endfunction

  function automatic int winner(input int last, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (last + k) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input bit v, input logic [4:0] a, input logic [31:0] d);
    req_valid[i]         = v;
    req_addr[i*5 +: 5]   = a;
    req_data[i*32 +: 32] = d;
  endtask

  // Compare one cycle's outputs against the model, then record this cycle's acceptance.
  task automatic step();
    int              w;
    logic [NREQ-1:0] er;
    logic [31:0]     ep;
    logic [4:0]      a;
    @(negedge clk);
    // The cycle right after a non-zero acceptance is the setup cycle: no arbitration.
    w  = nz_at(t - 1) ? -1 : winner(m_last, req_valid);
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    ep = '0;
    if (nz_at(t - 1)) ep[acc_addr[t-1]] = 1'b1;
    if (nz_at(t - 2)) ep[acc_addr[t-2]] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(er));
    check("write",     32'(write),     32'(nz_at(t - 2)));
    check("busy",      32'(busy),      32'(nz_at(t - 1) | nz_at(t - 2)));
    check("zero_drop", 32'(zero_drop), 32'(zero_at(t - 1)));
    check("pend_mask", pend_mask, ep);
    check("rgw1",      32'(rgw1), 32'(m_addr));
    check("rgw1data",  rgw1data, m_data);
    if (w >= 0) begin
      m_last = w;
      a = req_addr[w*5 +: 5];
      if (a != 5'd0) begin
        acc_nz[t]   = 1'b1;
        acc_addr[t] = a;
        m_addr      = a;
        m_data      = req_data[w*32 +: 32];
      end else begin
        acc_zero[t] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic clear_req();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 5'd0, 32'd0);
  endtask

  // Entered at posedge+1; asserts reset mid-cycle, checks reset values, releases mid-cycle.
  task automatic do_reset();
    #1 reset = 1'b0;
    req_valid = '1;
    #1;
    check("rst_write", 32'(write), 32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_pend",  pend_mask,  32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rgw1",  32'(rgw1), 32'd0);
    check("rst_data",  rgw1data, 32'd0);
    check("rst_zdrop", 32'(zero_drop), 32'd0);
    @(posedge clk);
    #1;
    t++;
    check("rst_ready_held", 32'(req_ready), 32'd0);
    check("rst_write_held", 32'(write), 32'd0);
    reset      = 1'b1;
    hist_start = t;
    m_last     = NREQ - 1;
    m_addr     = '0;
    m_data     = '0;
  endtask

  initial begin
    reset = 1'b0;
    clear_req();
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    clear_req();

    // Single write r5 from requester 1.
    set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
    step();
    clear_req();
    repeat (4) step();

    // All three requesters continuously valid: 0,1,2,0,... every 2 cycles.
    set_req(0, 1'b1, 5'd1, 32'h1111_0001);
    set_req(1, 1'b1, 5'd2, 32'h2222_0002);
    set_req(2, 1'b1, 5'd3, 32'h3333_0003);
    repeat (9) step();
    clear_req();
    repeat (3) step();

    // Write to $zero is dropped.
    set_req(0, 1'b1, 5'd0, 32'h0000_1234);
    step();
    clear_req();
    repeat (3) step();

    // Same-register collision on r7: set wins at strobe exit.
    set_req(0, 1'b1, 5'd7, 32'h7777_0000);
    step();
    clear_req();
    set_req(2, 1'b1, 5'd7, 32'h7777_0002);
    repeat (2) step();
    clear_req();
    repeat (4) step();

    // Reset during SETUP of r9; afterwards requester 0 wins first.
    set_req(0, 1'b1, 5'd9, 32'h9999_9999);
    step();
    do_reset();
    check("rst_setup_pend", pend_mask, 32'd0);
    set_req(0, 1'b1, 5'd10, 32'hA0A0_0000);
    set_req(1, 1'b1, 5'd11, 32'hB0B0_0001);
    set_req(2, 1'b1, 5'd12, 32'hC0C0_0002);
    repeat (4) step();
    clear_req();
    repeat (3) step();

    // Single requester valid: granted every 2 cycles.
    for (int n = 0; n < 8; n++) begin
      set_req(1, 1'b1, 5'($urandom_range(1, 31)), $urandom);
      step();
    end
    clear_req();
    repeat (3) step();

    // Random traffic with a small address range to provoke collisions and $zero writes.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++)
        set_req(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      step();
    end
    clear_req();
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
